div_ratio_meter: RTL

//  Receive-side counterpart of the ADPLL frequency divider: it measures the divided clock rather than generating it.

---
 rtl/div_ratio_meter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/div_ratio_meter.sv
// rtl/div_ratio_meter.sv - divided-clock period meter with lock and timeout detection
// Counts clk cycles between synchronized rising edges of div_in and tracks ratio stability.
module div_ratio_meter #(
   parameter int CNT_W    = 8,
   parameter int LOCK_CNT = 4,
   parameter int TIMEOUT  = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             div_in,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic             locked,
   output logic             timeout
);

   localparam int MW = $clog2(LOCK_CNT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT);
   localparam logic [MW-1:0]    M_ONE    = MW'(1);
   localparam logic [MW-1:0]    LOCK_VAL = MW'(LOCK_CNT);

   typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

   state_t           state_q, state_d;
   logic             sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [MW-1:0]    match_q, match_d;
   logic             valid_q, valid_d;
   logic             locked_q, locked_d;
   logic             timeout_q, timeout_d;
   logic             edge_det;
   logic             tmo_hit;

   always_comb begin
      sync1_d   = div_in;
      sync2_d   = sync1_q;
      sync3_d   = sync2_q;
      edge_det  = sync2_q & ~sync3_q;
      tmo_hit   = (cnt_q == TO_VAL) && !edge_det;
      state_d   = state_q;
      period_d  = period_q;
      match_d   = match_q;
      locked_d  = locked_q;
      valid_d   = 1'b0;
      timeout_d = 1'b0;
      if (edge_det)
         cnt_d = CNT_ONE;
      else if (cnt_q == CNT_MAX)
         cnt_d = cnt_q;
      else
         cnt_d = cnt_q + CNT_ONE;

      if (clear) begin
         state_d  = SEARCH;
         cnt_d    = '0;
         period_d = '0;
         match_d  = '0;
         locked_d = 1'b0;
      end else if (edge_det) begin
         if (state_q == SEARCH) begin
            // the first edge only starts the measurement window
            state_d = MEASURE;
         end else begin
            period_d = cnt_q;
            valid_d  = 1'b1;
            if (cnt_q == period_q) begin
               if (match_q < LOCK_VAL)
                  match_d = match_q + M_ONE;
               if ((match_q + M_ONE) >= LOCK_VAL) begin
                  state_d  = LOCKED;
                  locked_d = 1'b1;
               end
            end else begin
               match_d  = M_ONE;
               state_d  = MEASURE;
               locked_d = 1'b0;
            end
         end
      end else if (tmo_hit) begin
         timeout_d = 1'b1;
         cnt_d     = CNT_ONE;
         state_d   = SEARCH;
         period_d  = '0;
         match_d   = '0;
         locked_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= SEARCH;
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         sync3_q   <= 1'b0;
         cnt_q     <= '0;
         period_q  <= '0;
         match_q   <= '0;
         valid_q   <= 1'b0;
         locked_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         sync3_q   <= sync3_d;
         cnt_q     <= cnt_d;
         period_q  <= period_d;
         match_q   <= match_d;
         valid_q   <= valid_d;
         locked_q  <= locked_d;
         timeout_q <= timeout_d;
      end
   end

   assign period       = period_q;
   assign period_valid = valid_q;
   assign locked       = locked_q;
   assign timeout      = timeout_q;

endmodule
